// File: rtl/uart_pkg.sv
// Shared types for the configurable UART: parity selection, RX/TX state
// encodings and the bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic int bit_cycles(input int clockrate, input int baudrate);
        return clockrate / baudrate;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO: dout always presents the oldest entry while not empty.
// Push when full and pop when empty are ignored regardless of the other port.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by count_reg alone.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART with TX/RX FIFOs, parity, 1-2 stop bits and sticky
// frame/parity/overrun error flags.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int      CLOCKRATE  = 100000000,
    parameter int      BAUDRATE   = 9600,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_EVEN,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       send_flag,
    input  logic [7:0] send_data,
    input  logic       recv_flag,
    output logic [7:0] recv_data,
    output logic       sendable,
    output logic       receivable,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err,
    output logic       Tx,
    input  logic       Rx
);
    localparam int            BIT_CYCLES = bit_cycles(CLOCKRATE, BAUDRATE);
    localparam int            CW         = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(BIT_CYCLES / 2);
    localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    logic                 tx_full, tx_empty, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_empty, rx_full;
    logic [DATA_BITS-1:0] rx_head;

    generate
        if (DATA_BITS < 8) begin : g_unused
            logic unused_send_hi;
            assign unused_send_hi = ^send_data[7:DATA_BITS];
        end
    endgenerate

    // ---------------- FIFOs ----------------
    tx_state_t            tx_state_reg, tx_state_next;
    logic                 tx_reg, tx_next, tx_load;
    logic [CW-1:0]        baud_cnt_reg;
    logic [DATA_BITS-1:0] tx_data_reg, tx_data_next;
    logic                 tx_par_reg, tx_par_next;
    logic [2:0]           tx_bit_reg, tx_bit_next;
    logic                 tx_stop_reg, tx_stop_next;

    rx_state_t            rx_state_reg, rx_state_next;
    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
    logic [2:0]           rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_acc_reg, rx_acc_next;
    logic                 rx_bad_reg, rx_bad_next;
    logic                 rx_wr_reg, rx_wr_next;
    logic                 rx_sample, frame_ev, parity_ev, overrun_ev;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK(CLK), .RST_N(RST_N),
        .push(send_flag), .din(send_data[DATA_BITS-1:0]),
        .pop(tx_pop), .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK(CLK), .RST_N(RST_N),
        .push(rx_wr_reg), .din(rx_data_reg),
        .pop(recv_flag), .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign sendable   = !tx_full;
    assign receivable = !rx_empty;
    assign Tx         = tx_reg;

    always_comb begin
        recv_data = '0;
        if (!rx_empty) recv_data[DATA_BITS-1:0] = rx_head;
    end

    // ---------------- Transmitter ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state_reg <= TX_IDLE;
            tx_reg       <= 1'b1;
            baud_cnt_reg <= '0;
            tx_data_reg  <= '0;
            tx_par_reg   <= 1'b0;
            tx_bit_reg   <= '0;
            tx_stop_reg  <= 1'b0;
        end else begin
            baud_cnt_reg <= (baud_cnt_reg == CNT_LAST) ? '0 : baud_cnt_reg + CW'(1);
            tx_state_reg <= tx_state_next;
            tx_reg       <= tx_next;
            tx_data_reg  <= tx_data_next;
            tx_par_reg   <= tx_par_next;
            tx_bit_reg   <= tx_bit_next;
            tx_stop_reg  <= tx_stop_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_next       = tx_reg;
        tx_data_next  = tx_data_reg;
        tx_par_next   = tx_par_reg;
        tx_bit_next   = tx_bit_reg;
        tx_stop_next  = tx_stop_reg;
        tx_load       = 1'b0;
        if (baud_cnt_reg == '0) begin
            case (tx_state_reg)
                TX_IDLE: tx_load = !tx_empty;
                TX_START: begin
                    tx_next       = tx_data_reg[0];
                    tx_data_next  = tx_data_reg >> 1;
                    tx_bit_next   = '0;
                    tx_state_next = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit_reg == BIT_LAST) begin
                        tx_next       = (PARITY == PAR_NONE) ? 1'b1 : tx_par_reg;
                        tx_stop_next  = 1'b0;
                        tx_state_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        tx_next      = tx_data_reg[0];
                        tx_data_next = tx_data_reg >> 1;
                        tx_bit_next  = tx_bit_reg + 3'd1;
                    end
                end
                TX_PARITY: begin
                    tx_next       = 1'b1;
                    tx_stop_next  = 1'b0;
                    tx_state_next = TX_STOP;
                end
                TX_STOP: begin
                    // Chain straight into the next start bit so frames abut.
                    if (tx_stop_reg == STOP_LAST) begin
                        tx_load       = !tx_empty;
                        tx_state_next = TX_IDLE;
                    end else begin
                        tx_stop_next = 1'b1;
                    end
                end
                default: tx_state_next = TX_IDLE;
            endcase
        end
        if (tx_load) begin
            tx_next       = 1'b0;
            tx_data_next  = tx_head;
            tx_par_next   = (PARITY == PAR_ODD) ? ~^tx_head : ^tx_head;
            tx_state_next = TX_START;
        end
    end

    assign tx_pop = tx_load;

    // ---------------- Receiver ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_data_reg  <= '0;
            rx_acc_reg   <= 1'b0;
            rx_bad_reg   <= 1'b0;
            rx_wr_reg    <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            rx_meta_reg  <= Rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_data_reg  <= rx_data_next;
            rx_acc_reg   <= rx_acc_next;
            rx_bad_reg   <= rx_bad_next;
            rx_wr_reg    <= rx_wr_next;
            frame_err    <= frame_ev   | (frame_err   & ~err_clr);
            parity_err   <= parity_ev  | (parity_err  & ~err_clr);
            overrun_err  <= overrun_ev | (overrun_err & ~err_clr);
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = (rx_cnt_reg == CNT_LAST) ? '0 : rx_cnt_reg + CW'(1);
        rx_bit_next   = rx_bit_reg;
        rx_data_next  = rx_data_reg;
        rx_acc_next   = rx_acc_reg;
        rx_bad_next   = rx_bad_reg;
        rx_wr_next    = 1'b0;
        frame_ev      = 1'b0;
        parity_ev     = 1'b0;
        overrun_ev    = 1'b0;
        rx_sample     = (rx_cnt_reg == CNT_HALF);
        case (rx_state_reg)
            // A low stop bit leaves rx_prev low, so a new edge needs Rx high first.
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = RX_START;
                    rx_data_next  = '0;
                    rx_acc_next   = 1'b0;
                    rx_bad_next   = 1'b0;
                end
            end
            RX_START: begin
                rx_bit_next = '0;
                if (rx_sample) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_data_next[rx_bit_reg] = rx_sync_reg;
                    rx_acc_next              = rx_acc_reg ^ rx_sync_reg;
                    if (rx_bit_reg == BIT_LAST)
                        rx_state_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                    else
                        rx_bit_next = rx_bit_reg + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_state_next = RX_STOP;
                    if ((rx_acc_reg ^ rx_sync_reg) != (PARITY == PAR_ODD)) begin
                        parity_ev   = 1'b1;
                        rx_bad_next = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_next = RX_IDLE;
                    if (!rx_sync_reg)     frame_ev   = 1'b1;
                    else if (!rx_bad_reg) begin
                        if (rx_full)      overrun_ev = 1'b1;
                        else              rx_wr_next = 1'b1;
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

endmodule
